// File: rtl/counter_bank_updown.sv
// Bank of N_CNT independent up/down counters with a single-cycle command port,
// sticky per-channel wrap flags and a registered readback of one selected channel.
module counter_bank_updown #(
  parameter int WIDTH    = 32,
  parameter int N_CNT    = 89,
  parameter int ID_W     = $clog2(N_CNT),
  parameter int SATURATE = 0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [ID_W-1:0]  cmd_id,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [ID_W-1:0]  rd_id,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             any_wrap
);

  localparam logic [2:0] OP_START    = 3'd1;
  localparam logic [2:0] OP_STOP     = 3'd2;
  localparam logic [2:0] OP_CLEAR    = 3'd3;
  localparam logic [2:0] OP_LOAD     = 3'd4;
  localparam logic [2:0] OP_DIR_UP   = 3'd5;
  localparam logic [2:0] OP_DIR_DOWN = 3'd6;
  localparam logic [2:0] OP_CLR_FLAG = 3'd7;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [ID_W:0]    N_CNT_W = (ID_W+1)'(N_CNT);

  logic [N_CNT-1:0][WIDTH-1:0] cnt_all;
  logic [N_CNT-1:0]            wflag_all;

  for (genvar i = 0; i < N_CNT; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, step_cnt;
    logic             en_q, en_d, dir_q, dir_d, wflag_q, wflag_d;
    logic             step_wrap, hit;

    // Ids at or above N_CNT match no channel, so those commands fall through.
    assign hit = cmd_valid && (cmd_id == ID_W'(i));

    always_comb begin
      step_cnt  = cnt_q;
      step_wrap = 1'b0;
      if (en_q) begin
        if (!dir_q) begin
          step_wrap = (cnt_q == CNT_MAX);
          step_cnt  = (step_wrap && SATURATE != 0) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
          step_wrap = (cnt_q == '0);
          step_cnt  = (step_wrap && SATURATE != 0) ? cnt_q : cnt_q - CNT_ONE;
        end
      end
      cnt_d   = step_cnt;
      en_d    = en_q;
      dir_d   = dir_q;
      wflag_d = wflag_q | step_wrap;
      // CLEAR/LOAD drop this cycle's step entirely, including its wrap event.
      if (hit) begin
        case (cmd_op)
          OP_START:    en_d = 1'b1;
          OP_STOP:     en_d = 1'b0;
          OP_CLEAR: begin
            cnt_d   = '0;
            wflag_d = 1'b0;
          end
          OP_LOAD: begin
            cnt_d   = cmd_data;
            wflag_d = wflag_q;
          end
          OP_DIR_UP:   dir_d = 1'b0;
          OP_DIR_DOWN: dir_d = 1'b1;
          OP_CLR_FLAG: wflag_d = step_wrap;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        en_q    <= 1'b0;
        dir_q   <= 1'b0;
        wflag_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        dir_q   <= dir_d;
        wflag_q <= wflag_d;
      end
    end

    assign cnt_all[i]   = cnt_q;
    assign wflag_all[i] = wflag_q;
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d, any_wrap_q, any_wrap_d;

  always_comb begin
    count_d = '0;
    wrap_d  = 1'b0;
    if ({1'b0, rd_id} < N_CNT_W) begin
      count_d = cnt_all[rd_id];
      wrap_d  = wflag_all[rd_id];
    end
    any_wrap_d = |wflag_all;
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      any_wrap_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      any_wrap_q <= any_wrap_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign any_wrap = any_wrap_q;

endmodule

// File: doc/counter_bank_updown.md
# counter_bank_updown

Parametrised bank of N_CNT independent up/down counters sharing one clock, the next generation of the multi-instance counter benchmarks. Each channel has its own enable, direction and sticky wrap flag, all driven through a single-cycle command port. The selected channel's value and flag are returned through a registered readback port. The block targets FPGA architecture micro-benchmarks that scale width and instance count through parameters alone.

## Interface
- WIDTH, 32: counter width in bits (≥2).
- N_CNT, 89: number of counter channels (≥2).
- ID_W, $clog2(N_CNT): channel index width; derived, do not override.
- SATURATE, 0: 0 = counters wrap modulo 2^WIDTH; 1 = counters hold at the limit.

- clock0  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to clock0 upstream.
- cmd_valid  input  1  command strobe, one command per cycle.
- cmd_op  input  3  0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 LOAD, 5 DIR_UP, 6 DIR_DOWN, 7 CLR_FLAG.
- cmd_id  input  ID_W  target channel of the command.
- cmd_data  input  WIDTH  load value, used by LOAD only.
- rd_id  input  ID_W  readback channel select.
- count  output  WIDTH  registered count of channel rd_id.
- wrap  output  1  registered sticky wrap flag of channel rd_id.
- any_wrap  output  1  registered OR of all channels' wrap flags.

## Operation
- Per-channel state: cnt[WIDTH], en, dir (0 = up, 1 = down), wflag. All are flops; there is no combinational enable decode, so no latch.
- Reset values: cnt = 0, en = 0, dir = 0, wflag = 0; outputs count = 0, wrap = 0, any_wrap = 0.
- Counting: each cycle with en = 1, cnt advances by +1 when up and −1 when down.
- Wrap mode (SATURATE=0):
  - up from 2^WIDTH−1 goes to 0 and sets wflag;
  - down from 0 goes to 2^WIDTH−1 and sets wflag.
- Saturate mode (SATURATE=1):
  - up at 2^WIDTH−1 holds and sets wflag;
  - down at 0 holds and sets wflag.
- Commands act only on channel cmd_id and only when cmd_valid = 1:
  - START sets en = 1; STOP clears en = 0;
  - CLEAR sets cnt = 0 and wflag = 0, leaving en and dir unchanged;
  - LOAD sets cnt = cmd_data, leaving wflag unchanged;
  - DIR_UP / DIR_DOWN set dir;
  - CLR_FLAG clears wflag.
- Collision with counting: a CLEAR or LOAD on a channel takes priority over that channel's count step in the same cycle; the count step is dropped.
- START/STOP/DIR take effect from the next cycle; the step in the current cycle uses the old en/dir.
- Flag collision: CLR_FLAG in the same cycle as a wrap event leaves wflag = 1 (set wins).
- Out-of-range ids:
  - cmd_id ≥ N_CNT makes the command a no-op;
  - rd_id ≥ N_CNT returns count = 0 and wrap = 0.
- Untargeted channels continue counting unaffected by commands to other channels.

## Timing
- Command latency: a command sampled at edge k is visible in cnt after edge k.
- Readback latency: count/wrap reflect the post-edge-k state of rd_id at edge k+1 (one registered stage). The readback mux must be registered, not combinational.
- any_wrap has the same one-cycle latency.
- Reset mid-operation: all channels and outputs return to reset values asynchronously. The first count step occurs only after a START issued after reset release.
- Throughput: one command per cycle, back-to-back, with no stall.

## Test plan
- Reset, START ch 5 up, 10 cycles, rd_id = 5 -> count = 10 (one cycle after the 10th step); all other channels read 0; any_wrap = 0.
- LOAD ch 0 with 2^WIDTH−2, START, wait 3 steps, SATURATE=0 -> count sequence 2^WIDTH−1, 0, 1; wrap = 1; any_wrap = 1; CLR_FLAG -> wrap = 0 next readback.
- DIR_DOWN ch 88 (cnt 0), START, SATURATE=1 -> count stays 0 and wrap = 1; repeat with SATURATE=0 -> count = 2^WIDTH−1.
- ch 3 running up at 7, CLEAR in the same cycle as a step -> count = 0 next cycle, then 1, 2; en still 1.
- cmd_id = 100 and rd_id = 120 with N_CNT = 89 -> no channel state changes; count = 0, wrap = 0.
- Assert reset while 4 channels run with flags set -> count, wrap and any_wrap = 0 immediately; after release, counts stay 0 until a fresh START.
